// File: rtl/axi_slave_mem.sv
// AXI3 slave memory with independent write (AW/W/B) and read (AR/R) engines.
// Supports FIXED/INCR/WRAP bursts and byte strobes, and returns SLVERR on illegal or out-of-range beats.
module axi_slave_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 128
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [2:0]          awsize,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [LEN_W-1:0]    arlen,
  input  logic [2:0]          arsize,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);

  localparam int BYTES = DATA_W / 8;
  localparam int BL    = $clog2(BYTES);
  localparam int DL    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // Address of the beat that follows addr; WRAP folds back onto the beats*2^size window.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [LEN_W-1:0]  len,
                                                   input logic [2:0]        size,
                                                   input logic [1:0]        burst);
    logic [ADDR_W-1:0] step, inc, wsize, base;
    step  = ADDR_W'(1) << size;
    inc   = (addr & ~(step - ADDR_W'(1))) + step;
    wsize = (ADDR_W'(len) + ADDR_W'(1)) << size;
    base  = addr & ~(wsize - ADDR_W'(1));
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = base | (inc & (wsize - ADDR_W'(1)));
      default: next_addr = inc;
    endcase
  endfunction

  function automatic logic beat_err(input logic [ADDR_W-1:0] addr,
                                    input logic [LEN_W-1:0]  len,
                                    input logic [2:0]        size,
                                    input logic [1:0]        burst);
    logic wrap_bad;
    wrap_bad = (burst == 2'b10) &&
               !(int'(len) == 1 || int'(len) == 3 || int'(len) == 7 || int'(len) == 15);
    beat_err = (burst == 2'b11) || wrap_bad || (int'(size) > BL) || ({1'b0, addr} >= LIMIT);
  endfunction

  function automatic logic [DL-1:0] widx(input logic [ADDR_W-1:0] addr);
    widx = addr[BL+DL-1:BL];
  endfunction

  wstate_t           w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic [ID_W-1:0]   w_id;
  logic              w_err;
  logic              w_beat_err;
  logic              w_fire;

  rstate_t           r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;

  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic [2:0]        rd_size;
  logic [1:0]        rd_burst;
  logic              rd_err;
  logic [DATA_W-1:0] rd_word;

  assign w_fire     = (w_state == W_DATA) && wvalid && wready;
  assign w_beat_err = beat_err(w_addr, w_len, w_size, w_burst) || (wid != w_id) ||
                      (wlast != (w_cnt == w_len));

  always_ff @(posedge clk) begin
    if (w_fire && !w_beat_err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wstrb[i]) mem[widx(w_addr)][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_id    <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_id    <= awid;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_cnt  <= w_cnt + 1'b1;
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            if (w_beat_err) w_err <= 1'b1;
            // Completion is decided by the beat count, not by wlast.
            if (w_cnt == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // The read port looks up the beat about to be presented: beat 0 from AR, later beats from the latched burst.
  always_comb begin
    rd_addr  = araddr;
    rd_len   = arlen;
    rd_size  = arsize;
    rd_burst = arburst;
    if (r_state == R_DATA) begin
      rd_addr  = next_addr(r_addr, r_len, r_size, r_burst);
      rd_len   = r_len;
      rd_size  = r_size;
      rd_burst = r_burst;
    end
    rd_err  = beat_err(rd_addr, rd_len, rd_size, rd_burst);
    rd_word = mem[widx(rd_addr)];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= '0;
            rdata   <= rd_err ? '0 : rd_word;
            rresp   <= rd_err ? 2'b10 : 2'b00;
            rlast   <= (arlen == '0);
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_cnt == r_len) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_addr <= rd_addr;
              rdata  <= rd_err ? '0 : rd_word;
              rresp  <= rd_err ? 2'b10 : 2'b00;
              rlast  <= ((r_cnt + 1'b1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem at default parameters (32-bit data, 128 words).
// Each test task drives its own scenario and compares against hand-computed values.
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rstn;
  logic        awvalid, awready;
  logic [3:0]  awid, awlen;
  logic [2:0]  awsize;
  logic [31:0] awaddr;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid, arlen;
  logic [2:0]  arsize;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;
  int          w_lat, b_lat, r_lat;
  int          unstable;
  bit          timed_out;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awaddr(awaddr), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen), .arsize(arsize),
    .araddr(araddr), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Write burst driver; all timing and response results go to outputs/globals for the caller to check.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [3:0] wid_v,
                          input bit stall, output logic [1:0] resp, output logic [3:0] bid_v);
    int n;
    logic [1:0] r0;
    logic [3:0] i0;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) timed_out = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    n = 0;
    while (!wready && n < 200) begin @(posedge clk); #1; n++; end
    w_lat = n;
    for (int b = 0; b <= int'(len); b++) begin
      if (stall) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wvalid = 1'b1; wdata = wr_data[b]; wstrb = wr_strb[b]; wid = wid_v; wlast = (b == int'(len));
      n = 0;
      while (!wready && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) timed_out = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) timed_out = 1'b1;
    b_lat = n;
    if (stall) begin
      r0 = bresp; i0 = bid;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #1;
        if (!bvalid || bresp !== r0 || bid !== i0) unstable++;
      end
    end
    resp = bresp; bid_v = bid;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Read burst driver; records every accepted beat and counts output changes during rready stalls.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input bit stall);
    int n, b;
    bit have_prev;
    logic [31:0] pd;
    logic [1:0]  pr;
    logic        pl;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) timed_out = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 200) begin @(posedge clk); #1; n++; end
    r_lat = n;
    b = 0; n = 0; have_prev = 1'b0; pd = '0; pr = '0; pl = 1'b0;
    while (b <= int'(len) && n < 500) begin
      rready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rvalid) begin
        if (have_prev && (rdata !== pd || rresp !== pr || rlast !== pl)) unstable++;
        if (rready) begin
          rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast; rd_id = rid;
          b++;
          have_prev = 1'b0;
        end else begin
          pd = rdata; pr = rresp; pl = rlast; have_prev = 1'b1;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    if (b <= int'(len)) timed_out = 1'b1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    awvalid = 0; awid = 0; awlen = 0; awsize = 0; awaddr = 0; awburst = 0;
    wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; arlen = 0; arsize = 0; araddr = 0; arburst = 0; rready = 0;
    timed_out = 1'b0; unstable = 0;
    repeat (3) @(posedge clk);
    #1;
    n_compared++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp} !== 10'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp});
    end
    n_compared++;
    if ({rdata, rid, bid} !== 40'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got %h expected 0", {rdata, rid, bid});
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_compared++;
    if (awready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL awready_before_edge: got %b expected 0", awready);
    end
    @(posedge clk); #1;
    n_compared++;
    if ({awready, arready} !== 2'b11) begin
      n_mismatched++;
      $display("[TB] FAIL ready_after_release: got %b expected 11", {awready, arready});
    end
  endtask

  task automatic test_incr();
    logic [1:0] resp;
    logic [3:0] bid_v;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h11 * (i + 1); wr_strb[i] = 4'hF; end
    do_write(32'h10, 4'd3, 3'd2, 2'b01, 4'h5, 4'h5, 1'b0, resp, bid_v);
    n_compared++;
    if ({resp, bid_v} !== {2'b00, 4'h5}) begin
      n_mismatched++;
      $display("[TB] FAIL incr_bresp_bid: got %h/%h expected 0/5", resp, bid_v);
    end
    n_compared++;
    if (w_lat !== 0 || b_lat !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL incr_w_timing: got wlat %0d blat %0d expected 0 0", w_lat, b_lat);
    end
    n_compared++;
    if (awready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL incr_aw_reaccept: got %b expected 1", awready);
    end
    do_read(32'h10, 4'd3, 3'd2, 2'b01, 4'h9, 1'b0);
    n_compared++;
    if (r_lat !== 0 || rd_id !== 4'h9) begin
      n_mismatched++;
      $display("[TB] FAIL incr_r_lat_id: got %0d/%h expected 0/9", r_lat, rd_id);
    end
    for (int b = 0; b < 4; b++) begin
      n_compared++;
      if (rd_data[b] !== 32'h11 * (b + 1) || rd_resp[b] !== 2'b00 || rd_last[b] !== (b == 3)) begin
        n_mismatched++;
        $display("[TB] FAIL incr_beat%0d: got %h/%b/%b expected %h/00/%b",
                 b, rd_data[b], rd_resp[b], rd_last[b], 32'h11 * (b + 1), b == 3);
      end
    end
    n_compared++;
    if ({rvalid, arready, timed_out} !== 3'b010) begin
      n_mismatched++;
      $display("[TB] FAIL incr_r_end: got %b expected 010", {rvalid, arready, timed_out});
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp;
    logic [3:0] bid_v;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + i; wr_strb[i] = 4'hF; end
    do_write(32'h30, 4'd3, 3'd2, 2'b01, 4'h1, 4'h1, 1'b0, resp, bid_v);
    do_read(32'h38, 4'd3, 3'd2, 2'b10, 4'h2, 1'b0);
    for (int b = 0; b < 4; b++) begin
      n_compared++;
      if (rd_data[b] !== 32'hA0 + ((b + 2) % 4) || rd_resp[b] !== 2'b00) begin
        n_mismatched++;
        $display("[TB] FAIL wrap_beat%0d: got %h/%b expected %h/00", b, rd_data[b], rd_resp[b], 32'hA0 + ((b + 2) % 4));
      end
    end
  endtask

  task automatic test_strobe_fixed();
    logic [1:0] resp;
    logic [3:0] bid_v;
    wr_data[0] = 32'h0; wr_strb[0] = 4'hF;
    do_write(32'h0, 4'd0, 3'd2, 2'b01, 4'h0, 4'h0, 1'b0, resp, bid_v);
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'h5;
    do_write(32'h0, 4'd0, 3'd2, 2'b01, 4'h0, 4'h0, 1'b0, resp, bid_v);
    do_read(32'h0, 4'd0, 3'd2, 2'b01, 4'h0, 1'b0);
    n_compared++;
    if (rd_data[0] !== 32'h00BB00DD || rd_last[0] !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL strobe: got %h/%b expected 00bb00dd/1", rd_data[0], rd_last[0]);
    end
    for (int i = 0; i < 4; i++) begin wr_data[i] = i + 1; wr_strb[i] = 4'hF; end
    do_write(32'h40, 4'd3, 3'd2, 2'b00, 4'h3, 4'h3, 1'b0, resp, bid_v);
    do_read(32'h40, 4'd0, 3'd2, 2'b01, 4'h0, 1'b0);
    n_compared++;
    if (rd_data[0] !== 32'h4 || resp !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL fixed: got %h/%b expected 4/00", rd_data[0], resp);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [3:0] bid_v;
    for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
    wr_data[0] = 32'hC0FFEE00;
    do_write(32'h20, 4'd0, 3'd2, 2'b01, 4'h2, 4'h2, 1'b0, resp, bid_v);
    for (int i = 0; i < 4; i++) wr_data[i] = 32'h12345678;
    do_write(32'h200, 4'd0, 3'd2, 2'b01, 4'h2, 4'h2, 1'b0, resp, bid_v);
    n_compared++;
    if (resp !== 2'b10) begin n_mismatched++; $display("[TB] FAIL err_range_bresp: got %b expected 10", resp); end
    do_write(32'h20, 4'd0, 3'd2, 2'b11, 4'h2, 4'h2, 1'b0, resp, bid_v);
    n_compared++;
    if (resp !== 2'b10) begin n_mismatched++; $display("[TB] FAIL err_burst11_bresp: got %b expected 10", resp); end
    do_write(32'h20, 4'd0, 3'd2, 2'b01, 4'h3, 4'h4, 1'b0, resp, bid_v);
    n_compared++;
    if (resp !== 2'b10 || bid_v !== 4'h3) begin
      n_mismatched++;
      $display("[TB] FAIL err_wid_bresp: got %b/%h expected 10/3", resp, bid_v);
    end
    do_write(32'h20, 4'd2, 3'd2, 2'b10, 4'h2, 4'h2, 1'b0, resp, bid_v);
    n_compared++;
    if (resp !== 2'b10) begin n_mismatched++; $display("[TB] FAIL err_wrap_len_bresp: got %b expected 10", resp); end
    do_write(32'h20, 4'd0, 3'd3, 2'b01, 4'h2, 4'h2, 1'b0, resp, bid_v);
    n_compared++;
    if (resp !== 2'b10) begin n_mismatched++; $display("[TB] FAIL err_size_bresp: got %b expected 10", resp); end
    do_read(32'h20, 4'd0, 3'd2, 2'b01, 4'h0, 1'b0);
    n_compared++;
    if (rd_data[0] !== 32'hC0FFEE00 || rd_resp[0] !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL err_mem_unchanged_20: got %h/%b expected c0ffee00/00", rd_data[0], rd_resp[0]);
    end
    do_read(32'h0, 4'd0, 3'd2, 2'b01, 4'h0, 1'b0);
    n_compared++;
    if (rd_data[0] !== 32'h00BB00DD) begin
      n_mismatched++;
      $display("[TB] FAIL err_mem_unchanged_0: got %h expected 00bb00dd", rd_data[0]);
    end
    wr_data[0] = 32'h77;
    do_write(32'h1FC, 4'd0, 3'd2, 2'b01, 4'h0, 4'h0, 1'b0, resp, bid_v);
    do_read(32'h1FC, 4'd1, 3'd2, 2'b01, 4'h6, 1'b0);
    n_compared++;
    if (rd_data[0] !== 32'h77 || rd_resp[0] !== 2'b00 || rd_data[1] !== 32'h0 || rd_resp[1] !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL err_read_boundary: got %h/%b %h/%b expected 77/00 0/10",
               rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]);
    end
    do_read(32'h20, 4'd1, 3'd2, 2'b11, 4'h6, 1'b0);
    n_compared++;
    if (rd_data[0] !== 32'h0 || rd_resp[0] !== 2'b10 || rd_data[1] !== 32'h0 || rd_resp[1] !== 2'b10 || rd_last[1] !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL err_read_burst11: got %h/%b %h/%b expected 0/10 0/10",
               rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp, resp2;
    logic [3:0] bid_v;
    for (int i = 0; i < 16; i++) begin wr_data[i] = 32'h5000 + i; wr_strb[i] = 4'hF; end
    do_write(32'h180, 4'd15, 3'd2, 2'b01, 4'h0, 4'h0, 1'b0, resp, bid_v);
    for (int i = 0; i < 16; i++) wr_data[i] = 32'h1000 + i;
    unstable = 0;
    fork
      do_write(32'h100, 4'd15, 3'd2, 2'b01, 4'hA, 4'hA, 1'b1, resp2, bid_v);
      do_read(32'h180, 4'd15, 3'd2, 2'b01, 4'hB, 1'b1);
    join
    n_compared++;
    if (resp2 !== 2'b00 || bid_v !== 4'hA || rd_id !== 4'hB) begin
      n_mismatched++;
      $display("[TB] FAIL conc_ids: got %b/%h/%h expected 00/a/b", resp2, bid_v, rd_id);
    end
    for (int b = 0; b < 16; b++) begin
      n_compared++;
      if (rd_data[b] !== 32'h5000 + b || rd_resp[b] !== 2'b00 || rd_last[b] !== (b == 15)) begin
        n_mismatched++;
        $display("[TB] FAIL conc_read_beat%0d: got %h/%b/%b expected %h/00/%b",
                 b, rd_data[b], rd_resp[b], rd_last[b], 32'h5000 + b, b == 15);
      end
    end
    n_compared++;
    if (unstable !== 0) begin n_mismatched++; $display("[TB] FAIL conc_stall_stability: got %0d changes expected 0", unstable); end
    do_read(32'h100, 4'd15, 3'd2, 2'b01, 4'h0, 1'b0);
    for (int b = 0; b < 16; b++) begin
      n_compared++;
      if (rd_data[b] !== 32'h1000 + b) begin
        n_mismatched++;
        $display("[TB] FAIL conc_write_beat%0d: got %h expected %h", b, rd_data[b], 32'h1000 + b);
      end
    end
    n_compared++;
    if (timed_out !== 1'b0) begin n_mismatched++; $display("[TB] FAIL handshake_timeout: got %b expected 0", timed_out); end
  endtask

  task automatic test_reset_mid_burst();
    bit saw_b;
    awaddr = 32'h60; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awid = 4'h7; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wvalid = 1'b1; wdata = 32'hE0 + b; wstrb = 4'hF; wid = 4'h7; wlast = 1'b0;
      @(posedge clk); #1;
      wvalid = 1'b0;
    end
    #2 rstn = 1'b0;
    #1;
    n_compared++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_async: got %b expected 00000", {awready, wready, bvalid, arready, rvalid});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    n_compared++;
    if ({awready, wready} !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_release: got %b expected 10", {awready, wready});
    end
    saw_b = 1'b0;
    repeat (4) begin
      if (bvalid) saw_b = 1'b1;
      @(posedge clk); #1;
    end
    n_compared++;
    if (saw_b !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_no_bvalid: got %b expected 0", saw_b); end
    do_read(32'h60, 4'd1, 3'd2, 2'b01, 4'h0, 1'b0);
    n_compared++;
    if (rd_data[0] !== 32'hE0 || rd_data[1] !== 32'hE1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_kept_beats: got %h %h expected e0 e1", rd_data[0], rd_data[1]);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_strobe_fixed();
    test_errors();
    test_back_to_back();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
